// File: rtl/simd_lane_pkg.sv
// simd_lane_ci shared types and lane helpers.
// Lane math is width-generic via explicit w/sgn arguments.
package simd_lane_pkg;

  typedef enum logic [2:0] {
    OP_MAX     = 3'd0,
    OP_ADDSAT  = 3'd1,
    OP_ACCMAX  = 3'd2,
    OP_READCLR = 3'd3,
    OP_HMAX    = 3'd4,
    OP_RSV5    = 3'd5,
    OP_RSV6    = 3'd6,
    OP_RSV7    = 3'd7
  } ci_op_t;

  localparam int DATA_W_D = 32;
  localparam int LANE_W_D = 16;
  localparam bit SIGNED_D = 1'b1;
  localparam int LANES    = DATA_W_D / LANE_W_D;

  // Lane minimum as a w-bit pattern in the low bits.
  function automatic logic [31:0] lane_min_f(
    input int w,
    input bit sgn
  );
    logic [31:0] r;
    r = '0;
    if (sgn) r = 32'd1 << (w - 1);
    return r;
  endfunction

  // Lane maximum as a w-bit pattern in the low bits.
  function automatic logic [31:0] lane_max_f(
    input int w,
    input bit sgn
  );
    logic [32:0] r;
    if (sgn) r = (33'd1 << (w - 1)) - 33'd1;
    else     r = (33'd1 << w) - 33'd1;
    return r[31:0];
  endfunction

  localparam logic [31:0] LANE_MIN =
    lane_min_f(LANE_W_D, SIGNED_D);
  localparam logic [31:0] LANE_MAX =
    lane_max_f(LANE_W_D, SIGNED_D);

  // Extend a w-bit lane to a wide signed value.
  function automatic logic signed [33:0] lane_ext(
    input logic [31:0] v,
    input int          w,
    input bit          sgn
  );
    logic signed [33:0] m;
    logic signed [33:0] r;
    m = (34'sd1 <<< w) - 34'sd1;
    r = $signed({2'b00, v}) & m;
    if (sgn && v[w-1]) r = r | ~m;
    return r;
  endfunction

  function automatic logic [31:0] lane_max(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w,
    input bit          sgn
  );
    logic signed [33:0] ea;
    logic signed [33:0] eb;
    ea = lane_ext(a, w, sgn);
    eb = lane_ext(b, w, sgn);
    return (ea >= eb) ? a : b;
  endfunction

  // Sum is formed one bit wider than the lane, then clamped.
  function automatic logic [31:0] lane_addsat(
    input logic [31:0] a,
    input logic [31:0] b,
    input int          w,
    input bit          sgn
  );
    logic signed [33:0] s;
    logic signed [33:0] lo;
    logic signed [33:0] hi;
    s  = lane_ext(a, w, sgn) + lane_ext(b, w, sgn);
    lo = lane_ext(lane_min_f(w, sgn), w, sgn);
    hi = lane_ext(lane_max_f(w, sgn), w, sgn);
    if (s > hi)      s = hi;
    else if (s < lo) s = lo;
    return s[31:0];
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// Combinational datapath for LPC lanes of one step.
// HMAX threads a running max through the lanes.
module simd_lane_alu
  import simd_lane_pkg::*;
#(
  parameter int LANE_W = 16,
  parameter int LPC    = 1,
  parameter bit SGN    = 1'b1
) (
  input  logic [2:0]            op,
  input  logic [LPC*LANE_W-1:0] a,
  input  logic [LPC*LANE_W-1:0] b,
  input  logic [LPC*LANE_W-1:0] acc,
  input  logic [LANE_W-1:0]     hmax_in,
  output logic [LPC*LANE_W-1:0] res,
  output logic [LPC*LANE_W-1:0] acc_out,
  output logic [LANE_W-1:0]     hmax_out
);

  logic [LANE_W-1:0] ai;
  logic [LANE_W-1:0] bi;
  logic [LANE_W-1:0] ci;
  logic [LANE_W-1:0] mx;
  logic [LANE_W-1:0] hm;

  // Per-lane operation select and HMAX reduction.
  always_comb begin
    res     = '0;
    acc_out = acc;
    hm      = hmax_in;
    ai      = '0;
    bi      = '0;
    ci      = '0;
    mx      = '0;
    for (int i = 0; i < LPC; i++) begin
      ai = a[i*LANE_W +: LANE_W];
      bi = b[i*LANE_W +: LANE_W];
      ci = acc[i*LANE_W +: LANE_W];
      unique case (1'b1)
        (op == OP_MAX): begin
          res[i*LANE_W +: LANE_W] = LANE_W'(
            lane_max(32'(ai), 32'(bi), LANE_W, SGN));
        end
        (op == OP_ADDSAT): begin
          res[i*LANE_W +: LANE_W] = LANE_W'(
            lane_addsat(32'(ai), 32'(bi), LANE_W, SGN));
        end
        (op == OP_ACCMAX): begin
          mx = LANE_W'(
            lane_max(32'(ci), 32'(ai), LANE_W, SGN));
          res[i*LANE_W +: LANE_W]     = mx;
          acc_out[i*LANE_W +: LANE_W] = mx;
        end
        (op == OP_READCLR): begin
          res[i*LANE_W +: LANE_W] = ci;
        end
        (op == OP_HMAX): begin
          hm = LANE_W'(
            lane_max(32'(hm), 32'(ai), LANE_W, SGN));
        end
        default: ;
      endcase
    end
    hmax_out = hm;
  end

endmodule

// File: rtl/simd_lane_ci.sv
// Multi-cycle packed-lane custom instruction slave.
// FSM walks LPC lanes per cycle; acc persists across ops.
module simd_lane_ci
  import simd_lane_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 16,
  parameter int LPC    = 1,
  parameter int SIGNED = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic [2:0]        n,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int NL  = DATA_W / LANE_W;
  localparam int SW  = LPC * LANE_W;
  localparam int IW  = $clog2(NL + 1);
  localparam bit SGN = (SIGNED != 0);

  localparam logic [IW-1:0] STEP = IW'(LPC);
  localparam logic [IW-1:0] LAST = IW'(NL - LPC);

  localparam logic [LANE_W-1:0] LMIN =
    LANE_W'(lane_min_f(LANE_W, SGN));
  localparam logic [DATA_W-1:0] ACC_INIT = {NL{LMIN}};
  localparam logic [DATA_W-1:0] HMAX_SEED =
    SGN ? DATA_W'($signed(LMIN)) : DATA_W'(LMIN);
  localparam logic [DATA_W-1:0] SL_MASK =
    DATA_W'({SW{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] stage;
  logic [IW-1:0]     idx;

  int                sh;
  logic [SW-1:0]     a_sl;
  logic [SW-1:0]     b_sl;
  logic [SW-1:0]     c_sl;
  logic [SW-1:0]     res_sl;
  logic [SW-1:0]     acc_sl;
  logic [LANE_W-1:0] hm_out;
  logic [DATA_W-1:0] hm_ext;
  logic [DATA_W-1:0] stage_nx;
  logic [DATA_W-1:0] acc_nx;

  // Select the lane group at idx from the latched operands.
  always_comb begin
    sh   = LANE_W * int'(idx);
    a_sl = SW'(a_q >> sh);
    b_sl = SW'(b_q >> sh);
    c_sl = SW'(acc >> sh);
  end

  simd_lane_alu #(
    .LANE_W (LANE_W),
    .LPC    (LPC),
    .SGN    (SGN)
  ) u_alu (
    .op       (op_q),
    .a        (a_sl),
    .b        (b_sl),
    .acc      (c_sl),
    .hmax_in  (stage[LANE_W-1:0]),
    .res      (res_sl),
    .acc_out  (acc_sl),
    .hmax_out (hm_out)
  );

  // Merge the processed group back into staging and acc.
  always_comb begin
    if (SGN) hm_ext = DATA_W'($signed(hm_out));
    else     hm_ext = DATA_W'(hm_out);
    acc_nx = (acc & ~(SL_MASK << sh))
           | (DATA_W'(acc_sl) << sh);
    if (op_q == OP_HMAX) begin
      stage_nx = hm_ext;
    end else begin
      stage_nx = (stage & ~(SL_MASK << sh))
               | (DATA_W'(res_sl) << sh);
    end
  end

  // Control FSM with registered done/result; clk_en freezes all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= ACC_INIT;
      stage  <= '0;
      idx    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else if (clk_en) begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q <= n;
            a_q  <= dataa;
            b_q  <= datab;
            idx  <= '0;
            if (n > OP_HMAX) begin
              stage  <= '0;
              result <= '0;
              done   <= 1'b1;
              state  <= S_FIN;
            end else begin
              stage <= (n == OP_HMAX) ? HMAX_SEED : '0;
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          stage <= stage_nx;
          acc   <= acc_nx;
          idx   <= idx + STEP;
          if (idx == LAST) begin
            result <= stage_nx;
            done   <= 1'b1;
            state  <= S_FIN;
          end
        end
        S_FIN: begin
          done <= 1'b0;
          if (op_q == OP_READCLR) acc <= ACC_INIT;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
